// File: rtl/stacker_row_ctrl.sv
// Moving-row controller for the block-stacker game: frame-paced slide with edge bounce,
// drop/trim against the row below, speed-up per level and a req/ack handoff to the draw logic.
module stacker_row_ctrl #(
  parameter int unsigned GRID_W    = 10,
  parameter int unsigned ROWS      = 12,
  parameter int unsigned START_LEN = 3,
  parameter int unsigned BASE_FPS  = 3333332,
  parameter int unsigned FPS_STEP  = 208333,
  parameter int unsigned MIN_FPS   = 833332
) (
  input  logic              clk_i,
  input  logic              resetn_i,
  input  logic              start_i,
  input  logic              enable_frame_i,
  input  logic              drop_i,
  input  logic              draw_ack_i,
  output logic [GRID_W-1:0] row_mask_o,
  output logic [3:0]        row_idx_o,
  output logic [31:0]       fps_count_o,
  output logic              draw_req_o,
  output logic              game_over_o,
  output logic              win_o
);

  typedef enum logic [2:0] {StIdle, StMove, StCheck, StOver, StWin} state_e;

  localparam logic [GRID_W-1:0] StartMask  = GRID_W'((1 << START_LEN) - 1);
  localparam logic [31:0]       BaseFps    = 32'(BASE_FPS);
  localparam logic [31:0]       FpsStep    = 32'(FPS_STEP);
  localparam logic [31:0]       MinFps     = 32'(MIN_FPS);
  // Subtracting the step is only safe (and above the floor) at or above this value.
  localparam logic [31:0]       FloorThres = 32'(MIN_FPS + FPS_STEP);
  localparam logic [3:0]        LastRow    = 4'(ROWS - 1);

  state_e            state_q;
  logic [GRID_W-1:0] row_mask_q, prev_mask_q;
  logic              dir_left_q;
  logic [3:0]        row_idx_q;
  logic [31:0]       fps_q;
  logic              draw_req_q, game_over_q, win_q;
  logic              drop_q, drop_pend_q;

  logic              drop_rise;
  logic [GRID_W-1:0] new_mask;
  logic [GRID_W-1:0] shift_mask;
  logic              shift_dir_left;

  assign drop_rise = drop_i & ~drop_q;
  assign new_mask  = row_mask_q & prev_mask_q;

  // Bounce reverses direction and steps away from the edge within the same tick.
  always_comb begin
    shift_mask     = row_mask_q;
    shift_dir_left = dir_left_q;
    if (!dir_left_q) begin
      if (row_mask_q[GRID_W-1]) begin
        shift_mask     = row_mask_q >> 1;
        shift_dir_left = 1'b1;
      end else begin
        shift_mask = row_mask_q << 1;
      end
    end else begin
      if (row_mask_q[0]) begin
        shift_mask     = row_mask_q << 1;
        shift_dir_left = 1'b0;
      end else begin
        shift_mask = row_mask_q >> 1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q     <= StIdle;
      row_mask_q  <= StartMask;
      prev_mask_q <= '1;
      dir_left_q  <= 1'b0;
      row_idx_q   <= '0;
      fps_q       <= BaseFps;
      draw_req_q  <= 1'b0;
      game_over_q <= 1'b0;
      win_q       <= 1'b0;
      drop_q      <= 1'b0;
      drop_pend_q <= 1'b0;
    end else if (start_i) begin
      state_q     <= StMove;
      row_mask_q  <= StartMask;
      prev_mask_q <= '1;
      dir_left_q  <= 1'b0;
      row_idx_q   <= '0;
      fps_q       <= BaseFps;
      draw_req_q  <= 1'b1;
      game_over_q <= 1'b0;
      win_q       <= 1'b0;
      drop_q      <= 1'b0;
      drop_pend_q <= 1'b0;
    end else begin
      drop_q <= drop_i;
      // A new update later in this block overrides the ack clear.
      if (draw_ack_i) draw_req_q <= 1'b0;
      unique case (state_q)
        StMove: begin
          if (drop_pend_q && !draw_req_q) begin
            state_q     <= StCheck;
            drop_pend_q <= 1'b0;
          end else if (drop_rise) begin
            drop_pend_q <= 1'b1;
          end else if (enable_frame_i && !draw_req_q) begin
            row_mask_q <= shift_mask;
            dir_left_q <= shift_dir_left;
            draw_req_q <= 1'b1;
          end
        end
        StCheck: begin
          draw_req_q <= 1'b1;
          if (new_mask == '0) begin
            game_over_q <= 1'b1;
            state_q     <= StOver;
          end else if (row_idx_q == LastRow) begin
            prev_mask_q <= new_mask;
            row_mask_q  <= new_mask;
            win_q       <= 1'b1;
            state_q     <= StWin;
          end else begin
            prev_mask_q <= new_mask;
            row_mask_q  <= new_mask;
            row_idx_q   <= row_idx_q + 4'd1;
            fps_q       <= (fps_q >= FloorThres) ? (fps_q - FpsStep) : MinFps;
            state_q     <= StMove;
          end
        end
        default: ;
      endcase
    end
  end

  assign row_mask_o  = row_mask_q;
  assign row_idx_o   = row_idx_q;
  assign fps_count_o = fps_q;
  assign draw_req_o  = draw_req_q;
  assign game_over_o = game_over_q;
  assign win_o       = win_q;

endmodule

// File: tb/tb_stacker_row_ctrl.sv
// Directed bench for stacker_row_ctrl: slide/bounce, drop/trim, fps floor, miss, win,
// drop/tick collision and asynchronous reset.
module tb_stacker_row_ctrl;

  logic        clk = 1'b0;
  logic        resetn, start, enable_frame, drop, draw_ack;
  logic [9:0]  row_mask, row_mask2;
  logic [3:0]  row_idx, row_idx2;
  logic [31:0] fps_count, fps_count2;
  logic        draw_req, game_over, win, draw_req2, game_over2, win2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  stacker_row_ctrl #(.ROWS(16)) u_dut (
    .clk_i(clk), .resetn_i(resetn), .start_i(start), .enable_frame_i(enable_frame),
    .drop_i(drop), .draw_ack_i(draw_ack), .row_mask_o(row_mask), .row_idx_o(row_idx),
    .fps_count_o(fps_count), .draw_req_o(draw_req), .game_over_o(game_over), .win_o(win)
  );

  stacker_row_ctrl #(.ROWS(2)) u_dut_win (
    .clk_i(clk), .resetn_i(resetn), .start_i(start), .enable_frame_i(enable_frame),
    .drop_i(drop), .draw_ack_i(draw_ack), .row_mask_o(row_mask2), .row_idx_o(row_idx2),
    .fps_count_o(fps_count2), .draw_req_o(draw_req2), .game_over_o(game_over2), .win_o(win2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // All pulse tasks start and end on a falling edge, so outputs are sampled mid-cycle.
  task automatic do_tick();
    enable_frame = 1'b1;
    @(negedge clk);
    enable_frame = 1'b0;
  endtask

  task automatic do_ack();
    draw_ack = 1'b1;
    @(negedge clk);
    draw_ack = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic tick_ack(input int n);
    for (int i = 0; i < n; i++) begin
      do_tick();
      do_ack();
    end
  endtask

  // Rise drop and wait the three cycles until the CHECK results are visible.
  task automatic do_drop();
    drop = 1'b1;
    repeat (3) @(negedge clk);
    drop = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; enable_frame = 1'b0; drop = 1'b0; draw_ack = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_mask", row_mask, 32'h007);
    check_eq("rst_idx", row_idx, 0);
    check_eq("rst_fps", fps_count, 3333332);
    check_eq("rst_req", draw_req, 0);
    check_eq("rst_over", game_over, 0);
    check_eq("rst_win", win, 0);
    resetn = 1'b1;
    @(negedge clk);
    do_tick();
    check_eq("idle_tick_mask", row_mask, 32'h007);
    check_eq("idle_tick_req", draw_req, 0);

    do_start();
    check_eq("start_mask", row_mask, 32'h007);
    check_eq("start_req", draw_req, 1);
    do_ack();
    check_eq("ack_req", draw_req, 0);

    do_tick();
    check_eq("tick1_mask", row_mask, 32'h00E);
    check_eq("tick1_req", draw_req, 1);
    do_tick();
    check_eq("tick_blocked", row_mask, 32'h00E);
    do_ack();
    tick_ack(6);
    check_eq("slide_right", row_mask, 32'h380);
    do_tick();
    check_eq("bounce_right", row_mask, 32'h1C0);
    do_ack();
    tick_ack(3);
    check_eq("slide_left", row_mask, 32'h038);

    do_drop();
    check_eq("drop1_mask", row_mask, 32'h038);
    check_eq("drop1_idx", row_idx, 1);
    check_eq("drop1_fps", fps_count, 3124999);
    check_eq("drop1_req", draw_req, 1);
    do_ack();

    // Leftward through the bounce at column 0 and back out to 0x070.
    tick_ack(7);
    check_eq("row1_slid", row_mask, 32'h070);
    do_drop();
    check_eq("trim_mask", row_mask, 32'h030);
    check_eq("trim_idx", row_idx, 2);
    check_eq("trim_fps", fps_count, 2916666);
    do_ack();

    for (int i = 0; i < 10; i++) begin
      do_drop();
      do_ack();
    end
    check_eq("fps_k12", fps_count, 833336);
    check_eq("idx_k12", row_idx, 12);
    do_drop();
    do_ack();
    check_eq("fps_floor", fps_count, 833332);
    do_drop();
    do_ack();
    check_eq("fps_floor_hold", fps_count, 833332);
    check_eq("idx_k14", row_idx, 14);
    do_drop();
    do_ack();
    check_eq("idx_last", row_idx, 15);
    check_eq("win_not_yet", win, 0);
    do_drop();
    check_eq("win16", win, 1);
    check_eq("win16_idx", row_idx, 15);
    check_eq("win16_req", draw_req, 1);
    do_ack();
    do_tick();
    check_eq("win_tick_ignored", row_mask, 32'h030);

    do_start();
    check_eq("restart_win", win, 0);
    check_eq("restart_fps", fps_count, 3333332);
    do_ack();
    do_drop();
    do_ack();
    do_drop();
    check_eq("w2_win", win2, 1);
    check_eq("w2_idx", row_idx2, 1);
    check_eq("w2_mask", row_mask2, 32'h007);
    check_eq("main_idx2", row_idx, 2);
    do_ack();

    tick_ack(3);
    check_eq("pre_miss", row_mask, 32'h038);
    do_drop();
    check_eq("miss_over", game_over, 1);
    check_eq("miss_mask", row_mask, 32'h038);
    check_eq("miss_idx", row_idx, 2);
    check_eq("miss_fps", fps_count, 2916666);
    do_ack();
    do_tick();
    check_eq("over_tick", row_mask, 32'h038);
    check_eq("over_req", draw_req, 0);
    do_start();
    check_eq("restart_mask", row_mask, 32'h007);
    check_eq("restart_over", game_over, 0);
    do_ack();

    drop = 1'b1;
    enable_frame = 1'b1;
    @(negedge clk);
    enable_frame = 1'b0;
    check_eq("coll_noshift", row_mask, 32'h007);
    check_eq("coll_req", draw_req, 0);
    repeat (2) @(negedge clk);
    drop = 1'b0;
    check_eq("coll_idx", row_idx, 1);
    check_eq("coll_mask", row_mask, 32'h007);
    check_eq("coll_req2", draw_req, 1);
    do_ack();

    drop = 1'b1;
    repeat (2) @(negedge clk);
    resetn = 1'b0;
    #1;
    check_eq("arst_idx", row_idx, 0);
    check_eq("arst_fps", fps_count, 3333332);
    check_eq("arst_mask", row_mask, 32'h007);
    check_eq("arst_req", draw_req, 0);
    drop = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    do_start();
    resetn = 1'b0;
    #1;
    check_eq("arst_handshake", draw_req, 0);
    resetn = 1'b1;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
